pc_unit: RTL and testbench

Parametrised program-counter unit for the KGP-RISC fetch stage. It replaces the bare PC register with one block that does four things: sequential increment, stall hold, branch/jump redirect with fixed priority, and an optional return-address stack (RAS) for call/return. It sits between the branch-resolution logic and the instruction-memory address port. `pc_out` drives the fetch address; `pc_next` is exposed for the next-PC datapath.

---
 rtl/kgp_pc_pkg.sv | 16 +
 rtl/pc_ras.sv | 68 ++++++
 rtl/pc_unit.sv | 94 +++++++++
 tb/tb_pc_unit.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/kgp_pc_pkg.sv
// rtl/kgp_pc_pkg.sv - next-PC select encoding and default constants for pc_unit.
package kgp_pc_pkg;

  typedef enum logic [2:0] {
    SEL_RST,
    SEL_HOLD,
    SEL_RET,
    SEL_JMP,
    SEL_BR,
    SEL_SEQ
  } pc_sel_e;

  localparam int unsigned DEF_RESET_VEC = 0;
  localparam int unsigned DEF_INC       = 4;

endpackage

// File: rtl/pc_ras.sv
// rtl/pc_ras.sv - circular return-address stack; a push when full overwrites the oldest entry.
module pc_ras
  import kgp_pc_pkg::*;
#(
  parameter int AW    = 32,
  parameter int DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_stall,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [AW-1:0] i_data,
  output logic [AW-1:0] o_top,
  output logic          o_empty,
  output logic          o_full,
  output logic          o_ovf,
  output logic          o_unf
);

  localparam int PW = $clog2(DEPTH);

  logic [AW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_top;
  logic [PW:0]   r_cnt;
  logic          r_ovf;
  logic          r_unf;

  logic [PW-1:0] w_top_up;
  logic          w_do_push;
  logic          w_do_pop;

  // r_top points at the newest valid entry; the next push lands one slot above it.
  assign w_top_up  = r_top + PW'(1);
  assign w_do_pop  = i_pop & ~i_stall;
  assign w_do_push = i_push & ~i_stall & ~i_pop;

  assign o_top   = r_mem[r_top];
  assign o_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == (PW+1)'(DEPTH));
  assign o_ovf   = r_ovf;
  assign o_unf   = r_unf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_top <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else if (w_do_pop) begin
      if (o_empty) begin
        r_unf <= 1'b1;
      end else begin
        r_top <= r_top - PW'(1);
        r_cnt <= r_cnt - (PW+1)'(1);
      end
    end else if (w_do_push) begin
      r_top <= w_top_up;
      if (o_full) r_ovf <= 1'b1;
      else        r_cnt <= r_cnt + (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_do_push) r_mem[w_top_up] <= i_data;
  end

endmodule

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - fetch-stage PC: increment, stall, ret/jmp/branch redirect.
// Return-address stack compiled in with PC_RAS_EN.
module pc_unit
  import kgp_pc_pkg::*;
#(
  parameter int          AW        = 32,
  parameter int unsigned INC       = DEF_INC,
  parameter int unsigned RESET_VEC = DEF_RESET_VEC,
  parameter int          RAS_DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          br_taken,
  input  logic [AW-1:0] br_target,
  input  logic          jmp,
  input  logic          call,
  input  logic [AW-1:0] jmp_target,
  input  logic          ret,
  input  logic [AW-1:0] ret_target,
  output logic [AW-1:0] pc_out,
  output logic [AW-1:0] pc_next,
  output logic          ras_ovf,
  output logic          ras_unf
);

  localparam logic [AW-1:0] C_INC   = AW'(INC);
  localparam logic [AW-1:0] C_RSTV  = AW'(RESET_VEC);

  logic [AW-1:0] r_pc;
  logic [AW-1:0] w_pc_inc;
  logic [AW-1:0] w_ret_pc;
  pc_sel_e       w_sel;

  assign w_pc_inc = r_pc + C_INC;

  always_comb begin
    if (rst)           w_sel = SEL_RST;
    else if (stall)    w_sel = SEL_HOLD;
    else if (ret)      w_sel = SEL_RET;
    else if (jmp)      w_sel = SEL_JMP;
    else if (br_taken) w_sel = SEL_BR;
    else               w_sel = SEL_SEQ;
  end

`ifdef PC_RAS_EN
  logic [AW-1:0] w_ras_top;
  logic          w_ras_empty;
  logic          w_ras_full_unused;

  // The select already encodes priority, so a dropped call never pushes.
  pc_ras #(.AW(AW), .DEPTH(RAS_DEPTH)) u_ras (
    .clk     (clk),
    .rst     (rst),
    .i_stall (stall),
    .i_push  ((w_sel == SEL_JMP) & call),
    .i_pop   (w_sel == SEL_RET),
    .i_data  (w_pc_inc),
    .o_top   (w_ras_top),
    .o_empty (w_ras_empty),
    .o_full  (w_ras_full_unused),
    .o_ovf   (ras_ovf),
    .o_unf   (ras_unf)
  );

  assign w_ret_pc = w_ras_empty ? ret_target : w_ras_top;
`else
  logic w_call_unused;

  assign w_call_unused = call;
  assign w_ret_pc      = ret_target;
  assign ras_ovf       = 1'b0;
  assign ras_unf       = 1'b0;
`endif

  always_comb begin
    pc_next = w_pc_inc;
    case (w_sel)
      SEL_RST:  pc_next = C_RSTV;
      SEL_HOLD: pc_next = r_pc;
      SEL_RET:  pc_next = w_ret_pc;
      SEL_JMP:  pc_next = jmp_target;
      SEL_BR:   pc_next = br_target;
      default:  pc_next = w_pc_inc;
    endcase
  end

  always_ff @(posedge clk) begin
    r_pc <= pc_next;
  end

  assign pc_out = r_pc;

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - table-driven scoreboard bench for pc_unit (both PC_RAS_EN builds).
module tb_pc_unit;

`ifdef PC_RAS_EN
  localparam bit RAS = 1'b1;
`else
  localparam bit RAS = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall, br_taken, jmp, call, ret;
  logic [31:0] br_target, jmp_target, ret_target, pc_out, pc_next;
  logic        ras_ovf, ras_unf;

  pc_unit #(.AW(32), .INC(4), .RESET_VEC(0), .RAS_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .stall(stall), .br_taken(br_taken), .br_target(br_target),
    .jmp(jmp), .call(call), .jmp_target(jmp_target), .ret(ret), .ret_target(ret_target),
    .pc_out(pc_out), .pc_next(pc_next), .ras_ovf(ras_ovf), .ras_unf(ras_unf)
  );

  logic       b_rst, b_stall, b_br, b_jmp, b_call, b_ret;
  logic [7:0] b_bt, b_jt, b_rt, b_pc, b_pcn;
  logic       b_ovf, b_unf;

  pc_unit #(.AW(8), .INC(4), .RESET_VEC(8'hF0), .RAS_DEPTH(4)) dut8 (
    .clk(clk), .rst(b_rst), .stall(b_stall), .br_taken(b_br), .br_target(b_bt),
    .jmp(b_jmp), .call(b_call), .jmp_target(b_jt), .ret(b_ret), .ret_target(b_rt),
    .pc_out(b_pc), .pc_next(b_pcn), .ras_ovf(b_ovf), .ras_unf(b_unf)
  );

  typedef struct {
    logic        rst, stall, br;
    logic [31:0] bt;
    logic        jmp, call;
    logic [31:0] jt;
    logic        ret;
    logic [31:0] rt;
    logic [31:0] pc;
    logic        ovf, unf;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic        ovf, unf;
  } exp_t;

  vec_t tbl[$];
  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t v(logic r, logic s, logic b, logic [31:0] bt, logic j, logic c,
                             logic [31:0] jt, logic rr, logic [31:0] rt, logic [31:0] pc,
                             logic o, logic u);
    vec_t x;
    x.rst = r; x.stall = s; x.br = b; x.bt = bt; x.jmp = j; x.call = c; x.jt = jt;
    x.ret = rr; x.rt = rt; x.pc = pc; x.ovf = o; x.unf = u;
    return x;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step8(logic r, logic j, logic c, logic [7:0] jt, logic rr, logic [7:0] rt,
                       logic [7:0] exp_pc, logic exp_unf, string name);
    b_rst = r; b_jmp = j; b_call = c; b_jt = jt; b_ret = rr; b_rt = rt;
    @(posedge clk); #1;
    chk({name, "_pc"}, 32'(b_pc), 32'(exp_pc));
    chk({name, "_unf"}, 32'(b_unf), 32'(exp_unf));
  endtask

  initial begin
    exp_t e;
    rst = 1; stall = 0; br_taken = 0; jmp = 0; call = 0; ret = 0;
    br_target = 0; jmp_target = 0; ret_target = 0;
    b_rst = 1; b_stall = 0; b_br = 0; b_jmp = 0; b_call = 0; b_ret = 0;
    b_bt = 0; b_jt = 0; b_rt = 0;

    // rst stall br bt jmp call jt ret rt -> pc ovf unf
    tbl.push_back(v(0,0,0,0,     0,0,0,     0,0,     32'h4,  0,0));
    tbl.push_back(v(0,0,0,0,     0,0,0,     0,0,     32'h8,  0,0));
    tbl.push_back(v(0,0,0,0,     0,0,0,     0,0,     32'hC,  0,0));
    tbl.push_back(v(0,0,0,0,     0,0,0,     0,0,     32'h10, 0,0));
    tbl.push_back(v(0,1,1,'h80,  0,0,0,     0,0,     32'h10, 0,0));
    tbl.push_back(v(0,1,1,'h80,  0,0,0,     0,0,     32'h10, 0,0));
    tbl.push_back(v(0,0,0,0,     0,0,0,     0,0,     32'h14, 0,0));
    tbl.push_back(v(0,0,1,'h80,  1,0,'h200, 0,0,     32'h200,0,0));
    tbl.push_back(v(0,0,1,'h40,  0,0,0,     0,0,     32'h40, 0,0));
    tbl.push_back(v(0,0,0,0,     1,1,'h300, 0,0,     32'h300,0,0));
    tbl.push_back(v(0,0,0,0,     0,0,0,     0,0,     32'h304,0,0));
    tbl.push_back(v(0,0,0,0,     0,0,0,     1,'h999, RAS ? 32'h44 : 32'h999, 0,0));
    tbl.push_back(v(0,0,0,0,     1,0,'h0,   0,0,     32'h0,  0,0));
    tbl.push_back(v(0,0,0,0,     1,1,'h100, 0,0,     32'h100,0,0));
    tbl.push_back(v(0,0,0,0,     1,1,'h200, 0,0,     32'h200,0,0));
    tbl.push_back(v(0,0,0,0,     1,1,'h500, 0,0,     32'h500,RAS,0));
    tbl.push_back(v(0,0,0,0,     0,0,0,     1,'hABC, RAS ? 32'h204 : 32'hABC, RAS,0));
    tbl.push_back(v(0,0,0,0,     0,0,0,     1,'hABC, RAS ? 32'h104 : 32'hABC, RAS,0));
    tbl.push_back(v(0,0,0,0,     0,0,0,     1,'hABC, 32'hABC, RAS,RAS));
    tbl.push_back(v(0,1,0,0,     0,0,0,     1,'h111, 32'hABC, RAS,RAS));
    tbl.push_back(v(0,0,1,'h88,  1,1,'h700, 1,'h123, 32'h123, RAS,RAS));
    tbl.push_back(v(0,0,0,0,     0,0,0,     0,0,     32'h127,RAS,RAS));
    tbl.push_back(v(0,0,0,0,     1,1,'h800, 0,0,     32'h800,RAS,RAS));
    tbl.push_back(v(1,0,0,0,     1,1,'h900, 0,0,     32'h0,  0,0));
    tbl.push_back(v(0,0,0,0,     0,0,0,     1,'h55,  32'h55, 0,RAS));
    tbl.push_back(v(0,0,0,0,     0,0,0,     0,0,     32'h59, 0,RAS));

    @(posedge clk); @(posedge clk); #1;
    chk("reset_pc", pc_out, 32'h0);
    chk("reset_ovf", 32'(ras_ovf), 32'h0);
    chk("reset_unf", 32'(ras_unf), 32'h0);
    chk("reset8_pc", 32'(b_pc), 32'hF0);

    foreach (tbl[i]) begin
      rst = tbl[i].rst; stall = tbl[i].stall; br_taken = tbl[i].br; br_target = tbl[i].bt;
      jmp = tbl[i].jmp; call = tbl[i].call; jmp_target = tbl[i].jt;
      ret = tbl[i].ret; ret_target = tbl[i].rt;
      e.pc = tbl[i].pc; e.ovf = tbl[i].ovf; e.unf = tbl[i].unf;
      sbq.push_back(e);
      #1;
      chk($sformatf("v%0d_pc_next", i), pc_next, tbl[i].pc);
      @(posedge clk); #1;
      e = sbq.pop_front();
      chk($sformatf("v%0d_pc_out", i), pc_out, e.pc);
      chk($sformatf("v%0d_ovf", i), 32'(ras_ovf), 32'(e.ovf));
      chk($sformatf("v%0d_unf", i), 32'(ras_unf), 32'(e.unf));
    end
    rst = 0; stall = 0; br_taken = 0; jmp = 0; call = 0; ret = 0;

    b_rst = 0;
    step8(0,0,0,0,    0,0,    8'hF4, 0, "w_f4");
    step8(0,0,0,0,    0,0,    8'hF8, 0, "w_f8");
    step8(0,0,0,0,    0,0,    8'hFC, 0, "w_fc");
    #1;
    chk("w_pc_next_wrap", 32'(b_pcn), 32'h00);
    step8(0,0,0,0,    0,0,    8'h00, 0, "w_wrap");
    step8(0,0,0,0,    0,0,    8'h04, 0, "w_04");
    step8(0,1,1,8'h80,0,0,    8'h80, 0, "w_call");
    step8(1,1,1,8'hC0,0,0,    8'hF0, 0, "w_rst_call");
    step8(0,0,0,0,    1,8'h33,8'h33, RAS, "w_ret_after_rst");
    step8(0,0,0,0,    0,0,    8'h37, RAS, "w_after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
